// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Writeback stage of the integer pipeline. It takes the MEM/WB pipeline
// register outputs, picks the writeback value (load data or ALU result),
// commits that value into a 32 x XLEN register file, and serves two
// combinational read ports to the decode stage. It also keeps a count of
// retired instructions.
//
// Handshake: there is none. Every cycle with wb_valid = 1 is consumed, and
// there is no backpressure. Stalls reach this block as bubbles
// (wb_valid = 0).
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   wb_valid        MEM/WB slot holds a real instruction (0 = bubble)
//   regwrite        register write enable from MEM/WB control
//   memtoreg        1 = write read_data, 0 = write mem_alu_result
//   read_data       load data from MEM/WB
//   mem_alu_result  ALU result from MEM/WB
//   mem_write_reg   destination register index
//   rs1_addr        decode-stage source index, port 1
//   rs2_addr        decode-stage source index, port 2
//   rs1_data        source operand, port 1 (combinational)
//   rs2_data        source operand, port 2 (combinational)
//   wb_data         selected writeback value (combinational)
//   wb_we           effective write strobe this cycle (combinational)
//   instret         retired-instruction count (registered)
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_valid,
   input  logic             regwrite,
   input  logic             memtoreg,
   input  logic [XLEN-1:0]  read_data,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [4:0]       mem_write_reg,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_we,
   output logic [CNT_W-1:0] instret
);

   logic [XLEN-1:0]  r_regs [0:NREGS-1];
   logic [CNT_W-1:0] r_instret;

   logic [XLEN-1:0]  w_wb_data;
   logic             w_wb_we;
   logic [XLEN-1:0]  w_rs1_data;
   logic [XLEN-1:0]  w_rs2_data;

   // The writeback mux is driven even for bubbles; only the strobe is qualified.
   assign w_wb_data = memtoreg ? read_data : mem_alu_result;

   // rst_n is part of the strobe so that an in-flight write is dropped while
   // reset is held. Writes to x0 are suppressed here, so entry 0 is never
   // written after reset.
   assign w_wb_we = rst_n & wb_valid & regwrite & (mem_write_reg != 5'd0);

   // Read port: x0 reads as zero; a same-cycle write to the addressed register
   // is forwarded (write-through) so decode never sees a stale operand.
   always_comb begin
      w_rs1_data = r_regs[rs1_addr];
      if (rs1_addr == 5'd0) begin
         w_rs1_data = '0;
      end else if (w_wb_we && (rs1_addr == mem_write_reg)) begin
         w_rs1_data = w_wb_data;
      end
   end

   always_comb begin
      w_rs2_data = r_regs[rs2_addr];
      if (rs2_addr == 5'd0) begin
         w_rs2_data = '0;
      end else if (w_wb_we && (rs2_addr == mem_write_reg)) begin
         w_rs2_data = w_wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_instret <= '0;
      end else begin
         if (w_wb_we) begin
            r_regs[mem_write_reg] <= w_wb_data;
         end
         // Every real instruction retires, whether it writes a register or not.
         // The counter wraps naturally at 2^CNT_W.
         if (wb_valid) begin
            r_instret <= r_instret + 1'b1;
         end
      end
   end

   assign rs1_data = w_rs1_data;
   assign rs2_data = w_rs2_data;
   assign wb_data  = w_wb_data;
   assign wb_we    = w_wb_we;
   assign instret  = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed bench for wb_regfile. Inputs change 1 time unit after a rising
// edge. Combinational outputs are checked 1 time unit after that. A second
// instance with a 3-bit counter is fed the same inputs so that counter
// wrap-around can be reached in a few cycles.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic        regwrite;
   logic        memtoreg;
   logic [31:0] read_data;
   logic [31:0] mem_alu_result;
   logic [4:0]  mem_write_reg;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [63:0] instret;

   logic [31:0] n_rs1_data;
   logic [31:0] n_rs2_data;
   logic [31:0] n_wb_data;
   logic        n_wb_we;
   logic [2:0]  n_instret;

   int n_checks;
   int n_fail;

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid       (wb_valid),
      .regwrite       (regwrite),
      .memtoreg       (memtoreg),
      .read_data      (read_data),
      .mem_alu_result (mem_alu_result),
      .mem_write_reg  (mem_write_reg),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_data       (rs1_data),
      .rs2_data       (rs2_data),
      .wb_data        (wb_data),
      .wb_we          (wb_we),
      .instret        (instret)
   );

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(3)) dut_narrow (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid       (wb_valid),
      .regwrite       (regwrite),
      .memtoreg       (memtoreg),
      .read_data      (read_data),
      .mem_alu_result (mem_alu_result),
      .mem_write_reg  (mem_write_reg),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_data       (n_rs1_data),
      .rs2_data       (n_rs2_data),
      .wb_data        (n_wb_data),
      .wb_we          (n_wb_we),
      .instret        (n_instret)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs may then be changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held for two edges with a would-be write to x5 in flight.
      rst_n          = 1'b0;
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      memtoreg       = 1'b0;
      read_data      = 32'h0;
      mem_alu_result = 32'hDEADBEEF;
      mem_write_reg  = 5'd5;
      rs1_addr       = 5'd5;
      rs2_addr       = 5'd0;
      #1;
      check("we_in_reset", {63'd0, wb_we}, 64'd0);
      check("wbdata_in_reset", {32'd0, wb_data}, 64'hDEADBEEF);
      step();
      step();
      rst_n    = 1'b1;
      wb_valid = 1'b0;
      #1;
      check("rs1_after_reset", {32'd0, rs1_data}, 64'd0);
      check("instret_after_reset", instret, 64'd0);
      check("narrow_after_reset", {61'd0, n_instret}, 64'd0);

      // Mux and write: ALU result into x3, then load data into x4.
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      memtoreg       = 1'b0;
      mem_alu_result = 32'h12345678;
      read_data      = 32'hCAFEF00D;
      mem_write_reg  = 5'd3;
      #1;
      check("mux_alu", {32'd0, wb_data}, 64'h12345678);
      check("we_active", {63'd0, wb_we}, 64'd1);
      step();
      memtoreg      = 1'b1;
      mem_write_reg = 5'd4;
      #1;
      check("mux_load", {32'd0, wb_data}, 64'hCAFEF00D);
      step();
      wb_valid = 1'b0;
      rs1_addr = 5'd3;
      rs2_addr = 5'd4;
      #1;
      check("read_x3", {32'd0, rs1_data}, 64'h12345678);
      check("read_x4", {32'd0, rs2_data}, 64'hCAFEF00D);
      check("instret_2", instret, 64'd2);

      // Bypass: both ports hit the same-cycle write to x7.
      rs1_addr = 5'd7;
      rs2_addr = 5'd7;
      #1;
      check("x7_old", {32'd0, rs1_data}, 64'd0);
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      memtoreg       = 1'b0;
      mem_alu_result = 32'hA5A5A5A5;
      mem_write_reg  = 5'd7;
      #1;
      check("bypass_rs1", {32'd0, rs1_data}, 64'hA5A5A5A5);
      check("bypass_rs2", {32'd0, rs2_data}, 64'hA5A5A5A5);
      step();
      wb_valid       = 1'b0;
      mem_alu_result = 32'h0;
      #1;
      check("x7_stored", {32'd0, rs1_data}, 64'hA5A5A5A5);
      check("instret_3", instret, 64'd3);

      // regwrite = 0: no bypass, no write, but the instruction still retires.
      wb_valid       = 1'b1;
      regwrite       = 1'b0;
      mem_write_reg  = 5'd8;
      mem_alu_result = 32'h00000055;
      rs1_addr       = 5'd8;
      #1;
      check("nowrite_we", {63'd0, wb_we}, 64'd0);
      check("nowrite_nobypass", {32'd0, rs1_data}, 64'd0);
      step();
      wb_valid = 1'b0;
      #1;
      check("nowrite_x8", {32'd0, rs1_data}, 64'd0);
      check("instret_4", instret, 64'd4);

      // x0: write attempt is suppressed, read stays zero, still counted.
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      mem_write_reg  = 5'd0;
      mem_alu_result = 32'hFFFFFFFF;
      rs1_addr       = 5'd0;
      #1;
      check("x0_we", {63'd0, wb_we}, 64'd0);
      check("x0_same_cycle", {32'd0, rs1_data}, 64'd0);
      step();
      wb_valid = 1'b0;
      #1;
      check("x0_after", {32'd0, rs1_data}, 64'd0);
      check("instret_5", instret, 64'd5);

      // Put 0x77 into x9, then send a bubble that would overwrite it.
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      mem_write_reg  = 5'd9;
      mem_alu_result = 32'h00000077;
      step();
      wb_valid       = 1'b0;
      mem_alu_result = 32'h00000001;
      rs1_addr       = 5'd9;
      #1;
      check("bubble_we", {63'd0, wb_we}, 64'd0);
      check("bubble_nobypass", {32'd0, rs1_data}, 64'h77);
      check("instret_6", instret, 64'd6);
      step();
      check("bubble_x9", {32'd0, rs1_data}, 64'h77);
      check("bubble_instret", instret, 64'd6);

      // Counter wrap: the 3-bit instance goes 6 -> 7 -> 0; the 64-bit one keeps counting.
      wb_valid = 1'b1;
      regwrite = 1'b0;
      step();
      check("narrow_7", {61'd0, n_instret}, 64'd7);
      step();
      wb_valid = 1'b0;
      #1;
      check("narrow_wrap", {61'd0, n_instret}, 64'd0);
      check("instret_8", instret, 64'd8);

      // Reset mid-stream: the in-flight write to x10 is dropped and not counted.
      rst_n          = 1'b0;
      wb_valid       = 1'b1;
      regwrite       = 1'b1;
      memtoreg       = 1'b0;
      mem_write_reg  = 5'd10;
      mem_alu_result = 32'h0000BEEF;
      rs1_addr       = 5'd3;
      rs2_addr       = 5'd10;
      #1;
      check("midrst_we", {63'd0, wb_we}, 64'd0);
      check("midrst_x3_before", {32'd0, rs1_data}, 64'h12345678);
      check("midrst_x10_nobypass", {32'd0, rs2_data}, 64'd0);
      step();
      rst_n    = 1'b1;
      wb_valid = 1'b0;
      #1;
      check("midrst_x3_cleared", {32'd0, rs1_data}, 64'd0);
      check("midrst_x10", {32'd0, rs2_data}, 64'd0);
      check("midrst_instret", instret, 64'd0);

      // First write and count after release.
      wb_valid       = 1'b1;
      mem_alu_result = 32'h00000042;
      step();
      wb_valid = 1'b0;
      #1;
      check("post_rst_x10", {32'd0, rs2_data}, 64'h42);
      check("post_rst_instret", instret, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
